nand_logic_unit: RTL
====================

NAND_LOGIC_UNIT -- requirements
Module: nand_logic_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning operand width in bits; legal range 1..6.
REQ-002 SHALL provide parameter HOLD_CYCLES, default 1, meaning clock cycles each self-test vector is held; legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port op, input, 3 bits, function select.
REQ-006 SHALL have port A, input, WIDTH bits, operand A.
REQ-007 SHALL have port B, input, WIDTH bits, operand B.
REQ-008 SHALL have port in_valid, input, 1 bit, operands and op valid this cycle.
REQ-009 SHALL have port Z, output, WIDTH bits, registered result.
REQ-010 SHALL have port out_valid, output, 1 bit, Z updated this cycle.
REQ-011 SHALL have port bist_start, input, 1 bit, self-test request (level-sampled).
REQ-012 SHALL have port bist_busy, output, 1 bit, self-test running.
REQ-013 SHALL have port bist_done, output, 1 bit, self-test finished (level).
REQ-014 SHALL have port bist_pass, output, 1 bit, finished with zero mismatches.
REQ-015 SHALL have port err_count, output, 8 bits, saturating mismatch count.

Function
REQ-016 SHALL compute per bit: op 000 NAND, 001 AND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 BUF A.
REQ-017 SHALL build every datapath function exclusively from 2-input NAND primitives; no behavioural operators in the datapath.
REQ-018 SHALL register Z one cycle after in_valid sampled high; out_valid is in_valid delayed one cycle.
REQ-019 SHALL hold Z unchanged while in_valid is low or while bist_busy is high.
REQ-020 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on bist_start=1; RUN->DONE after last vector compared; DONE->RUN on bist_start=1.
REQ-021 SHALL in RUN drive the NAND datapath from an internal counter {op,A,B} of 3+2*WIDTH bits, ascending from 0, each vector held HOLD_CYCLES cycles.
REQ-022 SHALL compare registered datapath output against a behavioural golden model one cycle after each vector's final hold cycle; mismatch increments err_count, saturating at 255.
REQ-023 SHALL keep bist_busy high exactly 2^(3+2*WIDTH)*HOLD_CYCLES+1 cycles, starting the cycle after bist_start is sampled.
REQ-024 SHALL ignore functional inputs and force out_valid=0 while bist_busy=1; bist_start during RUN is ignored.
REQ-025 SHALL in DONE hold bist_done=1, bist_pass=(err_count==0), err_count stable; new start clears err_count, bist_done, bist_pass on entry to RUN.
REQ-026 SHALL when bist_start and in_valid are both high in IDLE, start self-test and discard the functional operation.

Reset
REQ-027 SHALL on rst=1 at a clock edge set Z=0, out_valid=0, FSM=IDLE, vector counter=0, bist_busy=0, bist_done=0, bist_pass=0, err_count=0.
REQ-028 SHALL abort a running self-test on reset mid-RUN without asserting bist_done; rst overrides bist_start in the same cycle.

Configuration
REQ-029 SHALL compile self-test logic only when macro NAND_LOGIC_BIST_EN is defined.
REQ-030 SHALL without NAND_LOGIC_BIST_EN tie bist_busy, bist_done, bist_pass to 0, err_count to 0, and ignore bist_start; functional path unchanged.

Verification
REQ-031 SHALL cover: WIDTH=4, op=010, A=4'b0101, B=4'b0011, in_valid=1 -> next cycle Z=4'b0111, out_valid=1.
REQ-032 SHALL cover: WIDTH=4, sweep all 8 ops with A=4'b1100, B=4'b1010 -> Z = 0111,1000,1110,0001,0110,1001,0011,1100.
REQ-033 SHALL cover: WIDTH=1, HOLD_CYCLES=1, pulse bist_start -> bist_busy high 33 cycles, then bist_done=1, bist_pass=1, err_count=0.
REQ-034 SHALL cover: WIDTH=2, HOLD_CYCLES=2, rst pulsed at busy cycle 40 -> all outputs 0, FSM IDLE; restart completes after 257 busy cycles with pass.
REQ-035 SHALL cover: forced-fault on one NAND output bit (bench force) during BIST, WIDTH=1 -> bist_pass=0, err_count nonzero.
REQ-036 SHALL cover: build without NAND_LOGIC_BIST_EN, bist_start=1 for 10 cycles -> bist_busy, bist_done stay 0; functional ops unaffected.

Source files
------------

// File: rtl/nand_logic_unit.sv
// nand_logic_unit: eight-function bitwise logic unit whose datapath is built only from 2-input NANDs.
// Optional built-in self-test is compiled in when the macro NAND_LOGIC_BIST_EN is defined.
module nand_logic_unit #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Z,
    output logic             out_valid,
    input  logic             bist_start,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass,
    output logic [7:0]       err_count
);

    function automatic logic nand2(input logic a, input logic b);
        return ~(a & b);
    endfunction

    // 2:1 select (s=0 -> d0, s=1 -> d1) expressed as four NANDs.
    function automatic logic mux2n(input logic s, input logic d0, input logic d1);
        return nand2(nand2(d0, nand2(s, s)), nand2(d1, s));
    endfunction

    function automatic logic [WIDTH-1:0] nand2v(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] y;
        for (int i = 0; i < WIDTH; i++) y[i] = nand2(a[i], b[i]);
        return y;
    endfunction

    logic [2:0]       dp_op;
    logic [WIDTH-1:0] dp_a, dp_b, nand_ab, dp_y;
    logic             start, accept;
    logic [WIDTH-1:0] z_q;
    logic             out_valid_q;

    // nand_ab is the shared first gate of every bit slice.
    assign nand_ab = nand2v(dp_a, dp_b);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic na, nb, f_and, f_or, f_nor, t1, t2, f_xor, f_xnor, f_buf;
        logic m0, m1, m2, m3, p0, p1;
        assign na     = nand2(dp_a[i], dp_a[i]);
        assign nb     = nand2(dp_b[i], dp_b[i]);
        assign f_and  = nand2(nand_ab[i], nand_ab[i]);
        assign f_or   = nand2(na, nb);
        assign f_nor  = nand2(f_or, f_or);
        assign t1     = nand2(dp_a[i], nand_ab[i]);
        assign t2     = nand2(dp_b[i], nand_ab[i]);
        assign f_xor  = nand2(t1, t2);
        assign f_xnor = nand2(f_xor, f_xor);
        assign f_buf  = nand2(na, na);
        assign m0     = mux2n(dp_op[0], nand_ab[i], f_and);
        assign m1     = mux2n(dp_op[0], f_or, f_nor);
        assign m2     = mux2n(dp_op[0], f_xor, f_xnor);
        assign m3     = mux2n(dp_op[0], na, f_buf);
        assign p0     = mux2n(dp_op[1], m0, m1);
        assign p1     = mux2n(dp_op[1], m2, m3);
        assign dp_y[i] = mux2n(dp_op[2], p0, p1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) z_q <= dp_y;
        end
    end

    assign Z         = z_q;
    assign out_valid = out_valid_q;

`ifdef NAND_LOGIC_BIST_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int             VW        = 3 + 2 * WIDTH;
    localparam logic [VW-1:0]  VEC_LAST  = {VW{1'b1}};
    localparam logic [3:0]     HOLD_LAST = 4'(HOLD_CYCLES - 1);

    function automatic logic [WIDTH-1:0] golden(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (o)
            3'd0:    return ~(a & b);
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    state_t           state_q;
    logic [VW-1:0]    vec_q;
    logic [3:0]       hold_q;
    logic             drain_q, cmp_q, busy_q, done_q, pass_q;
    logic [7:0]       err_q;
    logic [WIDTH-1:0] res_q, gold_q;
    logic [2:0]       vec_op;
    logic [WIDTH-1:0] vec_a, vec_b;
    logic             mismatch;

    assign vec_op   = vec_q[VW-1 -: 3];
    assign vec_a    = vec_q[2*WIDTH-1 -: WIDTH];
    assign vec_b    = vec_q[WIDTH-1:0];
    assign start    = bist_start && (state_q != RUN);
    assign accept   = in_valid && !busy_q && !start;
    assign dp_op    = busy_q ? vec_op : op;
    assign dp_a     = busy_q ? vec_a : A;
    assign dp_b     = busy_q ? vec_b : B;
    assign mismatch = cmp_q && (res_q != gold_q);

    // Datapath result and reference are captured together, compared on the next edge.
    always_ff @(posedge clk) begin
        res_q  <= dp_y;
        gold_q <= golden(vec_op, vec_a, vec_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            drain_q <= 1'b0;
            cmp_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            if (mismatch && err_q != 8'hFF) err_q <= err_q + 8'd1;
            case (state_q)
                IDLE, DONE: begin
                    if (bist_start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        vec_q   <= '0;
                        hold_q  <= '0;
                        drain_q <= 1'b0;
                        cmp_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (drain_q) begin
                        // Final cycle only resolves the last vector's comparison.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == 8'd0) && !mismatch;
                        drain_q <= 1'b0;
                        cmp_q   <= 1'b0;
                    end else begin
                        cmp_q <= (hold_q == HOLD_LAST);
                        if (hold_q == HOLD_LAST) begin
                            hold_q <= '0;
                            if (vec_q == VEC_LAST) drain_q <= 1'b1;
                            else                   vec_q   <= vec_q + VW'(1);
                        end else begin
                            hold_q <= hold_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bist_busy = busy_q;
    assign bist_done = done_q;
    assign bist_pass = pass_q;
    assign err_count = err_q;
`else
    localparam int unused_hold = HOLD_CYCLES;
    logic unused_bist_start;

    assign unused_bist_start = bist_start;
    assign start     = 1'b0;
    assign accept    = in_valid && !start;
    assign dp_op     = op;
    assign dp_a      = A;
    assign dp_b      = B;
    assign bist_busy = 1'b0;
    assign bist_done = 1'b0;
    assign bist_pass = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule
